// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with a frame-aligned run/stop controller,
// undelayed event strobes, delayed sync/DE and expanded, blank-gated colour.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int PIXEL_DELAY = 8,
  parameter int BPP         = 8,
  parameter int BPC         = 8,
  parameter int LINE_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BPP-1:0]       color,
  output logic [LINE_BITS-1:0] count_h,
  output logic [LINE_BITS-1:0] count_v,
  output logic                 running,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 vblank_start,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [BPC-1:0]       vga_r,
  output logic [BPC-1:0]       vga_g,
  output logic [BPC-1:0]       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [LINE_BITS-1:0] H_MAX    = LINE_BITS'(H_TOTAL - 1);
  localparam logic [LINE_BITS-1:0] V_MAX    = LINE_BITS'(V_TOTAL - 1);
  localparam logic [LINE_BITS-1:0] H_ACT    = LINE_BITS'(H_ACTIVE);
  localparam logic [LINE_BITS-1:0] V_ACT    = LINE_BITS'(V_ACTIVE);
  localparam logic [LINE_BITS-1:0] HS_START = LINE_BITS'(H_ACTIVE + H_FP);
  localparam logic [LINE_BITS-1:0] HS_END   = LINE_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LINE_BITS-1:0] VS_START = LINE_BITS'(V_ACTIVE + V_FP);
  localparam logic [LINE_BITS-1:0] VS_END   = LINE_BITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LINE_BITS-1:0] ONE      = LINE_BITS'(1);
  localparam int RB = (BPP + 2) / 3;
  localparam int GB = (BPP + 1) / 3;
  localparam int BB = BPP / 3;
  localparam int FW = $clog2(BPP);
  localparam int OW = (BPC > 1) ? $clog2(BPC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_e;

  state_e                 state_q;
  logic [LINE_BITS-1:0]   h_q, v_q, h_d, v_d;
  logic                   frame_start_q, line_start_q, vblank_start_q;
  logic                   frame_end_s, active_s, hs_lvl_s, vs_lvl_s, de_s;
  logic [PIXEL_DELAY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;
  logic [BPP-1:0]         r_fld_s, g_fld_s, b_fld_s;

  // MSB-first replication of a w-bit field (held in the LSBs of fld), truncated to BPC.
  function automatic logic [BPC-1:0] expand(input logic [BPP-1:0] fld, input int w);
    logic [BPC-1:0] res;
    res = '0;
    for (int i = 0; i < BPC; i++) begin
      res[OW'(BPC - 1 - i)] = fld[FW'(w - 1 - (i % w))];
    end
    return res;
  endfunction

  // Next raster position when the counters advance.
  always_comb begin
    frame_end_s = (h_q == H_MAX) && (v_q == V_MAX);
    if (h_q == H_MAX) begin
      h_d = '0;
      if (v_q == V_MAX) begin
        v_d = '0;
      end else begin
        v_d = v_q + ONE;
      end
    end else begin
      h_d = h_q + ONE;
      v_d = v_q;
    end
  end

  // Run/stop controller with counters and strobes registered alongside the position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      h_q            <= '0;
      v_q            <= '0;
      frame_start_q  <= 1'b0;
      line_start_q   <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          h_q            <= '0;
          v_q            <= '0;
          vblank_start_q <= 1'b0;
          if (enable) begin
            state_q       <= RUN;
            frame_start_q <= 1'b1;
            line_start_q  <= 1'b1;
          end else begin
            state_q       <= IDLE;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
          end
        end
        RUN, STOPPING: begin
          // A pending stop only takes effect on the last pixel of the frame.
          if (!enable && (state_q == STOPPING) && frame_end_s) begin
            state_q        <= IDLE;
            h_q            <= '0;
            v_q            <= '0;
            frame_start_q  <= 1'b0;
            line_start_q   <= 1'b0;
            vblank_start_q <= 1'b0;
          end else begin
            if (enable) begin
              state_q <= RUN;
            end else begin
              state_q <= STOPPING;
            end
            h_q            <= h_d;
            v_q            <= v_d;
            frame_start_q  <= (h_d == '0) && (v_d == '0);
            line_start_q   <= (h_d == '0);
            vblank_start_q <= (h_d == '0) && (v_d == V_ACT);
          end
        end
        default: begin
          state_q        <= IDLE;
          h_q            <= '0;
          v_q            <= '0;
          frame_start_q  <= 1'b0;
          line_start_q   <= 1'b0;
          vblank_start_q <= 1'b0;
        end
      endcase
    end
  end

  // Sync and data-enable levels for the current position, parked inactive while idle.
  always_comb begin
    active_s = (state_q != IDLE);
    if (active_s && (h_q >= HS_START) && (h_q < HS_END)) begin
      hs_lvl_s = HS_POL;
    end else begin
      hs_lvl_s = ~HS_POL;
    end
    if (active_s && (v_q >= VS_START) && (v_q < VS_END)) begin
      vs_lvl_s = VS_POL;
    end else begin
      vs_lvl_s = ~VS_POL;
    end
    de_s = active_s && (h_q < H_ACT) && (v_q < V_ACT);
  end

  // Delay line matching the pixel pipeline; reset flushes it so no partial pulse escapes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe_q <= {PIXEL_DELAY{~HS_POL}};
      vs_pipe_q <= {PIXEL_DELAY{~VS_POL}};
      de_pipe_q <= '0;
    end else begin
      hs_pipe_q[0] <= hs_lvl_s;
      vs_pipe_q[0] <= vs_lvl_s;
      de_pipe_q[0] <= de_s;
      for (int i = 1; i < PIXEL_DELAY; i++) begin
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
        de_pipe_q[i] <= de_pipe_q[i-1];
      end
    end
  end

  assign r_fld_s = BPP'(color[BPP-1 -: RB]);
  assign g_fld_s = BPP'(color[BB +: GB]);
  assign b_fld_s = BPP'(color[BB-1:0]);

  assign count_h      = h_q;
  assign count_v      = v_q;
  assign running      = (state_q != IDLE);
  assign frame_start  = frame_start_q;
  assign line_start   = line_start_q;
  assign vblank_start = vblank_start_q;
  assign vga_hs       = hs_pipe_q[PIXEL_DELAY-1];
  assign vga_vs       = vs_pipe_q[PIXEL_DELAY-1];
  assign vga_de       = de_pipe_q[PIXEL_DELAY-1];
  assign vga_r        = vga_de ? expand(r_fld_s, RB) : '0;
  assign vga_g        = vga_de ? expand(g_fld_s, GB) : '0;
  assign vga_b        = vga_de ? expand(b_fld_s, BB) : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a small raster (M), a tiny positive-polarity raster (T) and the
// default 640x480 raster (D) share clock, reset, enable and colour.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic [7:0] color;

  logic [7:0]  m_h, m_v, m_r, m_g, m_b;
  logic        m_run, m_fs, m_ls, m_vb, m_hs, m_vs, m_de;
  logic [3:0]  t_h, t_v, t_r, t_g, t_b;
  logic        t_run, t_fs, t_ls, t_vb, t_hs, t_vs, t_de;
  logic [11:0] d_h, d_v;
  logic [7:0]  d_r, d_g, d_b;
  logic        d_run, d_fs, d_ls, d_vb, d_hs, d_vs, d_de;

  // M: H 8/2/3/3 (total 16), V 6/1/2/1 (total 10), delay 3, active-low syncs
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_DELAY(3),
    .BPP(8), .BPC(8), .LINE_BITS(8)
  ) u_m (
    .clk(clk), .reset(reset), .enable(enable), .color(color),
    .count_h(m_h), .count_v(m_v), .running(m_run), .frame_start(m_fs),
    .line_start(m_ls), .vblank_start(m_vb), .vga_hs(m_hs), .vga_vs(m_vs),
    .vga_de(m_de), .vga_r(m_r), .vga_g(m_g), .vga_b(m_b)
  );

  // T: H 4/1/1/1 (total 7), V 2/1/1/1 (total 5), delay 1, active-high syncs, 1-bit fields
  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_DELAY(1),
    .BPP(3), .BPC(4), .LINE_BITS(4)
  ) u_t (
    .clk(clk), .reset(reset), .enable(enable), .color(color[2:0]),
    .count_h(t_h), .count_v(t_v), .running(t_run), .frame_start(t_fs),
    .line_start(t_ls), .vblank_start(t_vb), .vga_hs(t_hs), .vga_vs(t_vs),
    .vga_de(t_de), .vga_r(t_r), .vga_g(t_g), .vga_b(t_b)
  );

  video_timing_gen u_d (
    .clk(clk), .reset(reset), .enable(enable), .color(color),
    .count_h(d_h), .count_v(d_v), .running(d_run), .frame_start(d_fs),
    .line_start(d_ls), .vblank_start(d_vb), .vga_hs(d_hs), .vga_vs(d_vs),
    .vga_de(d_de), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int e        = 0;

  typedef struct {
    int         e;
    logic [7:0] color;
    int         h, v;
    logic       run, fs, ls, vb, hs, vs, de;
    logic [7:0] r, g, b;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (e=%0d): got %0h, expected %0h", name, e, act, exp);
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int n = 0;
    while (!((m_h == 8'(h)) && (m_v == 8'(v))) && (n < 400)) begin
      tick();
      n++;
    end
    chk({"reach_", name}, 32'(n < 400), 32'd1);
  endtask

  initial begin
    int d_ls1, d_ls2, m_fs_cnt, n;
    logic [7:0] lh, lv;

    // Entry at edge e after enabling (M position = e-1, M video output = position e-4).
    tbl[0]  = '{1,   8'hAE, 0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{4,   8'hAE, 3,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB6, 8'h6D, 8'hAA};
    tbl[2]  = '{5,   8'hFF, 4,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[3]  = '{11,  8'h31, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h24, 8'h92, 8'h55};
    tbl[4]  = '{12,  8'hAE, 11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{14,  8'hAE, 13, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{16,  8'hAE, 15, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{17,  8'hAE, 0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{97,  8'hAE, 0,  6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{116, 8'hAE, 3,  7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{144, 8'hAE, 15, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{148, 8'hAE, 3,  9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{160, 8'hAE, 15, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[13] = '{161, 8'hAE, 0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[14] = '{165, 8'hAE, 4,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB6, 8'h6D, 8'hAA};

    reset  = 1'b1;
    enable = 1'b0;
    color  = 8'hFF;
    repeat (3) tick();
    chk("rst_m_h", m_h, 0);          chk("rst_m_v", m_v, 0);
    chk("rst_m_run", m_run, 0);      chk("rst_m_strobes", {m_fs, m_ls, m_vb}, 0);
    chk("rst_m_hs", m_hs, 1);        chk("rst_m_vs", m_vs, 1);
    chk("rst_m_de", m_de, 0);        chk("rst_m_rgb", {m_r, m_g, m_b}, 0);
    chk("rst_t_hs", t_hs, 0);        chk("rst_t_vs", t_vs, 0);
    chk("rst_t_run", t_run, 0);      chk("rst_d_sync", {d_hs, d_vs, d_de}, 3'b110);
    chk("rst_d_cnt", {d_h, d_v}, 0);

    // Released but not enabled: stays idle.
    reset = 1'b0;
    tick(); tick();
    chk("idle_m_run", m_run, 0);
    chk("idle_m_cnt", {m_h, m_v}, 0);

    enable = 1'b1;
    e = 0;
    tick();
    chk("first_d_frame_start", d_fs, 1);
    chk("first_t_frame_start", t_fs, 1);

    for (int i = 0; i < 15; i++) begin
      while (e < tbl[i].e) tick();
      color = tbl[i].color;
      #1;
      chk("tbl_h",   m_h,   32'(tbl[i].h));
      chk("tbl_v",   m_v,   32'(tbl[i].v));
      chk("tbl_run", m_run, tbl[i].run);
      chk("tbl_fs",  m_fs,  tbl[i].fs);
      chk("tbl_ls",  m_ls,  tbl[i].ls);
      chk("tbl_vb",  m_vb,  tbl[i].vb);
      chk("tbl_hs",  m_hs,  tbl[i].hs);
      chk("tbl_vs",  m_vs,  tbl[i].vs);
      chk("tbl_de",  m_de,  tbl[i].de);
      chk("tbl_r",   m_r,   tbl[i].r);
      chk("tbl_g",   m_g,   tbl[i].g);
      chk("tbl_b",   m_b,   tbl[i].b);
    end

    // Default raster line timing and the tiny raster's wrap points.
    d_ls1 = -1; d_ls2 = -1; m_fs_cnt = 0;
    while (e < 1700) begin
      tick();
      if (d_ls) begin
        if (d_ls1 < 0) d_ls1 = e;
        else if (d_ls2 < 0) d_ls2 = e;
      end
      if (m_fs) m_fs_cnt++;
      case (e)
        664:  chk("d_hs_before", d_hs, 1);
        665:  begin chk("d_hs_start", d_hs, 0); chk("d_vs_line0", d_vs, 1); end
        760:  chk("d_hs_last", d_hs, 0);
        761:  chk("d_hs_after", d_hs, 1);
        808:  chk("d_de_before", d_de, 0);
        809:  chk("d_de_start", d_de, 1);
        1448: chk("d_de_last", d_de, 1);
        1449: chk("d_de_after", d_de, 0);
        1001: chk("t_sync_a", {t_h, t_v, t_hs, t_vs, t_de}, {4'd6, 4'd2, 3'b100});
        1002: chk("t_sync_b", {t_h, t_v, t_hs, t_vs, t_de}, {4'd0, 4'd3, 3'b000});
        1003: chk("t_sync_c", {t_h, t_v, t_hs, t_vs, t_de}, {4'd1, 4'd3, 3'b010});
        1050: chk("t_wrap_last", {t_h, t_v}, {4'd6, 4'd4});
        1051: chk("t_wrap_zero", {t_h, t_v, t_fs}, {4'd0, 4'd0, 1'b1});
        1053: begin
          color = 8'hAD;
          #1;
          chk("t_de", t_de, 1);
          chk("t_rgb_1bit", {t_r, t_g, t_b}, {4'hF, 4'h0, 4'hF});
        end
        default: ;
      endcase
    end
    chk("d_line_start_1", d_ls1, 801);
    chk("d_line_start_2", d_ls2, 1601);
    chk("m_frame_count", m_fs_cnt, 9);

    // Drop enable mid-frame: the frame completes, then the raster parks at (0,0).
    wait_pos(5, 3, "stop_point");
    enable = 1'b0;
    tick();
    chk("stopping_run", m_run, 1);
    chk("stopping_cnt", {m_h, m_v}, {8'd6, 8'd3});
    n = 1; lh = m_h; lv = m_v;
    while (m_run && (n < 400)) begin
      lh = m_h; lv = m_v;
      tick();
      n++;
    end
    chk("stop_cycles", n, 107);
    chk("stop_last_pos", {lh, lv}, {8'd15, 8'd9});
    chk("stop_idle_cnt", {m_h, m_v, m_fs, m_ls}, 0);
    repeat (3) tick();
    chk("stop_drained", {m_hs, m_vs, m_de, m_h, m_v}, {3'b110, 16'd0});
    enable = 1'b1;
    tick();
    chk("restart", {m_run, m_h, m_v, m_fs}, {1'b1, 16'd0, 1'b1});

    // Reset with sync active in the pipeline and enable still high.
    wait_pos(12, 4, "reset_point");
    reset = 1'b1;
    color = 8'hFF;
    tick();
    chk("midrst_cnt", {m_h, m_v}, 0);
    chk("midrst_run", m_run, 0);
    chk("midrst_hs", m_hs, 1);
    chk("midrst_vs_de", {m_vs, m_de}, 2'b10);
    chk("midrst_rgb", {m_r, m_g, m_b}, 0);
    chk("midrst_t_sync", {t_hs, t_vs, t_de}, 0);
    tick();
    chk("midrst_hold", {m_run, m_hs, m_de}, 3'b010);
    reset = 1'b0;
    tick();
    chk("midrst_release", {m_run, m_h, m_v, m_fs}, {1'b1, 16'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
